// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle main control FSM for the MIPS core.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles, plus one per memory wait cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold with mem_req stable until i_mem_ready.
//
// Ports:
//   i_clk, i_reset        rising-edge clock, synchronous active-high reset
//   i_op, i_funct         instruction[31:26] / [5:0] from the instruction register
//   i_zero                ALU zero flag (beq)
//   i_mem_ready           memory completed the current access this cycle
//   o_mem_req/o_memwrite  memory request and write strobe, o_iord address select
//   o_irwrite/o_pcwrite/o_regwrite  datapath enables
//   o_regdst/o_memtoreg/o_alusrca/o_alusrcb/o_pcsrc/o_zeroext  mux selects
//   o_alucontrol          4-bit ALU operation, o_illegal one-cycle fault pulse
//   o_state               current state encoding (debug)
//
// Build option: define MIPS_CTRL_IMMLOGIC_EN to add andi/ori (state LOGIEX).
module mips_mc_control (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_memwrite,
  output logic       o_iord,
  output logic       o_irwrite,
  output logic       o_pcwrite,
  output logic       o_regwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_pcsrc,
  output logic       o_zeroext,
  output logic [3:0] o_alucontrol,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_LOGIEX  = 4'd12
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_CTRL_IMMLOGIC_EN
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_req, w_memwrite, w_iord, w_irwrite, w_pcwrite;
  logic       w_regwrite, w_regdst, w_memtoreg, w_alusrca, w_illegal;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [3:0] w_alucontrol;
`ifdef MIPS_CTRL_IMMLOGIC_EN
  logic       w_zeroext;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_FETCH;
    else         r_state <= w_next;
  end

  // Next state and per-state outputs; FETCH and BEQEX carry Mealy terms.
  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_memwrite   = 1'b0;
    w_iord       = 1'b0;
    w_irwrite    = 1'b0;
    w_pcwrite    = 1'b0;
    w_regwrite   = 1'b0;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = 2'b00;
    w_pcsrc      = 2'b00;
    w_alucontrol = ALU_AND;
    w_illegal    = 1'b0;
`ifdef MIPS_CTRL_IMMLOGIC_EN
    w_zeroext    = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alusrcb    = 2'b01;
        w_alucontrol = ALU_ADD;
        w_irwrite    = i_mem_ready;
        w_pcwrite    = i_mem_ready;
        if (i_mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precomputed here so BEQEX can select ALUOut.
        w_alusrcb    = 2'b11;
        w_alucontrol = ALU_ADD;
        case (i_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef MIPS_CTRL_IMMLOGIC_EN
          OP_ANDI, OP_ORI: w_next = S_LOGIEX;
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b10;
        w_alucontrol = ALU_ADD;
        w_next       = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        if (i_mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req  = 1'b1;
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        if (i_mem_ready) w_next = S_FETCH;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_next    = S_RTYPEWB;
        case (i_funct)
          6'b100000: w_alucontrol = ALU_ADD;
          6'b100010: w_alucontrol = ALU_SUB;
          6'b100100: w_alucontrol = ALU_AND;
          6'b100101: w_alucontrol = ALU_OR;
          6'b101010: w_alucontrol = ALU_SLT;
          6'b000000: w_alucontrol = ALU_SLL;
          default: begin
            // Unsupported funct: abort before writeback.
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = ALU_SUB;
        w_pcsrc      = 2'b01;
        w_pcwrite    = i_zero;
        w_next       = S_FETCH;
      end
      S_ADDIEX: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b10;
        w_alucontrol = ALU_ADD;
        w_next       = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
`ifdef MIPS_CTRL_IMMLOGIC_EN
      S_LOGIEX: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b10;
        w_zeroext    = 1'b1;
        w_alucontrol = (i_op == OP_ORI) ? ALU_OR : ALU_AND;
        w_next       = S_ADDIWB;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // Reset forces every strobe and select low, even mid memory wait.
  assign o_mem_req    = i_reset ? 1'b0  : w_mem_req;
  assign o_memwrite   = i_reset ? 1'b0  : w_memwrite;
  assign o_iord       = i_reset ? 1'b0  : w_iord;
  assign o_irwrite    = i_reset ? 1'b0  : w_irwrite;
  assign o_pcwrite    = i_reset ? 1'b0  : w_pcwrite;
  assign o_regwrite   = i_reset ? 1'b0  : w_regwrite;
  assign o_regdst     = i_reset ? 1'b0  : w_regdst;
  assign o_memtoreg   = i_reset ? 1'b0  : w_memtoreg;
  assign o_alusrca    = i_reset ? 1'b0  : w_alusrca;
  assign o_alusrcb    = i_reset ? 2'b00 : w_alusrcb;
  assign o_pcsrc      = i_reset ? 2'b00 : w_pcsrc;
  assign o_alucontrol = i_reset ? 4'b0000 : w_alucontrol;
  assign o_illegal    = i_reset ? 1'b0  : w_illegal;
`ifdef MIPS_CTRL_IMMLOGIC_EN
  assign o_zeroext    = i_reset ? 1'b0  : w_zeroext;
`else
  assign o_zeroext    = 1'b0;
`endif
  assign o_state      = r_state;

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle main control FSM for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives the datapath enables, the mux selects and the 4-bit ALU operation code. It also performs a request/ready handshake with the unified instruction/data memory. It replaces the single-cycle combinational decode and sits between the instruction register (op/funct inputs), the ALU `zero` flag, and the datapath muxes.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `op`  in  6  instruction[31:26], from the instruction register
- `funct`  in  6  instruction[5:0]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory has completed the current access this cycle
- `mem_req`  out  1  memory access request
- `memwrite`  out  1  write strobe; qualifies `mem_req`
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut
- `irwrite`  out  1  load the instruction register
- `pcwrite`  out  1  load the PC
- `regwrite`  out  1  register file write
- `regdst`  out  1  destination: 0 = rt, 1 = rd
- `memtoreg`  out  1  writeback data: 0 = ALUOut, 1 = MDR
- `alusrca`  out  1  ALU A: 0 = PC, 1 = rs
- `alusrcb`  out  2  ALU B: 00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `zeroext`  out  1  immediate zero-extend select
- `alucontrol`  out  4  ALU operation code
- `illegal`  out  1  one-cycle pulse on an unsupported op or funct
- `state`  out  4  current state encoding, for debug

## Operation
ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLL 1110, SLT 0111.

States, with their encodings and the outputs they assert (any output not listed is 0):
- FETCH (0): `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, ADD, `pcsrc`=00.
  - `irwrite` and `pcwrite` = `mem_ready`.
  - Stay while `mem_ready`=0; go to DECODE when it is 1.
- DECODE (1): `alusrca`=0, `alusrcb`=11, ADD. Next state by `op`:
  - 100011 or 101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - anything else → FETCH with `illegal`=1
- MEMADR (2): `alusrca`=1, `alusrcb`=10, ADD. Go to MEMRD for lw, MEMWR for sw.
- MEMRD (3): `mem_req`=1, `iord`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB (4): `regwrite`=1, `regdst`=0, `memtoreg`=1. Go to FETCH.
- MEMWR (5): `mem_req`=1, `memwrite`=1, `iord`=1. Hold until `mem_ready`, then go to FETCH.
- RTYPEEX (6): `alusrca`=1, `alusrcb`=00. `alucontrol` from `funct`:
  - 100000 → ADD
  - 100010 → SUB
  - 100100 → AND
  - 100101 → OR
  - 101010 → SLT
  - 000000 → SLL
  - Any other `funct`: `illegal`=1, go to FETCH, no writeback. Otherwise go to RTYPEWB.
- RTYPEWB (7): `regwrite`=1, `regdst`=1, `memtoreg`=0. Go to FETCH.
- BEQEX (8): `alusrca`=1, `alusrcb`=00, SUB, `pcsrc`=01, `pcwrite`=`zero`. Go to FETCH.
- ADDIEX (9): `alusrca`=1, `alusrcb`=10, ADD. Go to ADDIWB.
- ADDIWB (10): `regwrite`=1, `regdst`=0, `memtoreg`=0. Go to FETCH.
- JEX (11): `pcsrc`=10, `pcwrite`=1. Go to FETCH.

## Timing
- State register updates on the rising edge of `clk`. Outputs are combinational from the state, except the Mealy terms: `irwrite` and `pcwrite` in FETCH, and `pcwrite` in BEQEX.
- Cycle counts with zero memory wait:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_req`, `iord` and `memwrite` stay stable for the whole wait. Removing `mem_req` before `mem_ready` is forbidden.
- `mem_ready` is ignored in every state that does not assert `mem_req`.
- While `reset`=1:
  - every enable and strobe output is forced to 0: `mem_req`, `memwrite`, `irwrite`, `pcwrite`, `regwrite`, `illegal`;
  - all selects read 0;
  - `alucontrol`=0000.
- The state loads FETCH on the edge where `reset`=1. This holds from any state, including mid memory wait; the pending access is abandoned.
- `illegal` is high for exactly the single DECODE or RTYPEEX cycle that detects the fault.

## Configuration
- `MIPS_CTRL_IMMLOGIC_EN` defined:
  - adds opcode 001100 (andi) and 001101 (ori) via state LOGIEX (12), then ADDIWB;
  - LOGIEX drives `alusrca`=1, `alusrcb`=10, `zeroext`=1, and AND or OR respectively;
  - both instructions take 4 cycles.
- Macro undefined: both opcodes are illegal in DECODE and `zeroext` is tied to 0.

## Test plan
- Reset asserted mid-MEMRD wait → next state 0, `mem_req`=0 while `reset`=1. After release, FETCH with `mem_req`=1 and `iord`=0.
- lw with `mem_ready`=1 always → states 0,1,2,3,4. MEMWB has `regwrite`=1 and `memtoreg`=1. Total 5 cycles.
- sw with `mem_ready` held low for 3 cycles in MEMWR → `memwrite`=1 for 4 cycles, then FETCH, `regwrite` never set.
- R-type with `funct`=101010 → `alucontrol`=0111 in state 6. With `funct`=000000 → 1110. With `funct`=111111 → `illegal` pulses once, next state 0.
- beq with `zero`=1 → `pcwrite`=1, `pcsrc`=01 in state 8. With `zero`=0 → `pcwrite`=0. Both take 3 cycles.
- `op`=001101 → with the macro: state 12, `alucontrol`=0001, `zeroext`=1, then state 10. Without it: `illegal`=1 in DECODE.
